sd_cmd_ctrl: RTL and testbench
==============================

SD_CMD_CTRL -- requirements
Module: sd_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1000: clock cycles allowed in WAIT_RESP before a timeout error is flagged.
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_write  input  1  one-cycle pulse indicating the CPU wrote the 00Eh command register.
REQ-005 SHALL have port cmd_index_in  input  6  command index from 00Eh[13:8].
REQ-006 SHALL have port cmd_argument_in  input  32  argument from 008h.
REQ-007 SHALL have port response_type_in  input  2  response type from 00Eh[1:0]: 00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy.
REQ-008 SHALL have port index_check_en_in  input  1  index-check enable from 00Eh[4].
REQ-009 SHALL have port new_command  output  1  one-cycle start pulse to the CMD block.
REQ-010 SHALL have port cmd_index  output  6  latched index presented to the CMD block.
REQ-011 SHALL have port cmd_argument  output  32  latched argument presented to the CMD block.
REQ-012 SHALL have port timeout_enable  output  1  high while WAIT_RESP is active.
REQ-013 SHALL have port command_complete  input  1  CMD block transfer-done pulse.
REQ-014 SHALL have port command_index_error  input  1  CMD block index mismatch; valid with command_complete.
REQ-015 SHALL have port enable_response  input  1  CMD block response-valid level, held until ack.
REQ-016 SHALL have port response_in  input  128  response from the CMD block.
REQ-017 SHALL have port ack_response  output  1  one-cycle acknowledge to the CMD block.
REQ-018 SHALL have port response_out  output  128  captured response to register 010h.
REQ-019 SHALL have port resp_wr  output  1  one-cycle write strobe to register 010h.
REQ-020 SHALL have port cmd_inhibit  output  1  high while a command is in flight.
REQ-021 SHALL have port int_status  output  3  sticky flags: [0] command complete, [1] timeout error, [2] index error.
REQ-022 SHALL have port int_clear  input  3  write-1-to-clear per int_status bit.

Function
REQ-023 SHALL implement the states IDLE, ISSUE, WAIT_RESP, LATCH and DONE.
REQ-024 In IDLE, cmd_write SHALL latch cmd_index_in, cmd_argument_in, response_type_in and index_check_en_in, then transition to ISSUE on the next cycle.
REQ-025 ISSUE SHALL assert new_command for exactly one cycle, then transition to WAIT_RESP.
REQ-026 cmd_inhibit SHALL be high in every state except IDLE.
REQ-027 cmd_write received while cmd_inhibit is high SHALL be ignored, with no change to latched fields or state.
REQ-028 WAIT_RESP SHALL count cycles from 0; the count reaching TIMEOUT_CYCLES-1 without command_complete SHALL set int_status[1] and transition to DONE.
REQ-029 In WAIT_RESP, command_complete SHALL transition to LATCH when the response type is non-zero, and to DONE when it is 00.
REQ-030 command_complete and timeout in the same cycle SHALL resolve as complete, with no timeout flag set.
REQ-031 command_complete with command_index_error=1 and index check enabled SHALL set int_status[2]; command_index_error with index check disabled SHALL be ignored.
REQ-032 LATCH SHALL wait for enable_response=1, then in that same cycle assert ack_response and resp_wr for one cycle, register response_in into response_out, and transition to DONE.
REQ-033 For type 10 or 11, response_out SHALL store response_in[47:0] with bits [127:48] zeroed; for type 01 it SHALL store all 128 bits.
REQ-034 LATCH SHALL have no timeout.
REQ-035 DONE SHALL set int_status[0] unless the timeout flag was set this command, then transition to IDLE after one cycle.
REQ-036 Command-to-command latency SHALL be: cmd_write to new_command is 2 cycles; DONE to IDLE is 1 cycle; a new cmd_write is accepted in the first IDLE cycle.
REQ-037 int_status bits SHALL remain set until cleared by int_clear; a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-038 response_out SHALL hold its value between commands; commands with type 00 or a timeout SHALL leave it unchanged.

Reset
REQ-039 Asserting reset low SHALL immediately force IDLE and zero all outputs, latched fields and the counter, regardless of state, including mid-command.
REQ-040 ack_response SHALL NOT be issued after reset for a response that was pending before reset.

Verification
REQ-041 A bench SHALL cover: cmd_write with index 6'd8, argument 32'h000001AA, type 10 -> new_command 2 cycles later with matching outputs; enable_response with response_in=128'hFFFF_0000_0000_0000_0000_1234_5678_9ABC -> resp_wr and ack the same cycle, response_out=128'h0000_0000_0000_0000_0000_1234_5678_9ABC, int_status=3'b001.
REQ-042 A bench SHALL cover: type 00 command completing -> no resp_wr, response_out unchanged, int_status=3'b001.
REQ-043 A bench SHALL cover: no command_complete for TIMEOUT_CYCLES cycles -> int_status=3'b010, cmd_inhibit low one cycle later; a complete pulse arriving in the final count cycle -> int_status=3'b001.
REQ-044 A bench SHALL cover: index check enabled with command_index_error=1 -> int_status=3'b101; with index check disabled -> 3'b001.
REQ-045 A bench SHALL cover: a second cmd_write while in WAIT_RESP -> ignored, cmd_index unchanged; int_clear=3'b001 coinciding with a DONE set -> bit 0 stays 1.
REQ-046 A bench SHALL cover: reset asserted in LATCH -> all outputs 0 asynchronously, no ack_response after release.

Source files
------------

// File: rtl/sd_cmd_ctrl_if.sv
// Bus bundle between the SD host register block, the command controller and the CMD line block.
// The controller uses the slave modport. The register/CMD side uses the master modport.
interface sd_cmd_ctrl_if;
  // CPU register side
  logic         cmd_write;
  logic [5:0]   cmd_index_in;
  logic [31:0]  cmd_argument_in;
  logic [1:0]   response_type_in;
  logic         index_check_en_in;
  logic [2:0]   int_clear;
  logic [127:0] response_out;
  logic         resp_wr;
  logic         cmd_inhibit;
  logic [2:0]   int_status;
  // CMD line block side
  logic         new_command;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic         timeout_enable;
  logic         command_complete;
  logic         command_index_error;
  logic         enable_response;
  logic [127:0] response_in;
  logic         ack_response;

  modport slave (
    input  cmd_write, cmd_index_in, cmd_argument_in, response_type_in, index_check_en_in,
    input  int_clear, command_complete, command_index_error, enable_response, response_in,
    output response_out, resp_wr, cmd_inhibit, int_status,
    output new_command, cmd_index, cmd_argument, timeout_enable, ack_response
  );

  modport master (
    output cmd_write, cmd_index_in, cmd_argument_in, response_type_in, index_check_en_in,
    output int_clear, command_complete, command_index_error, enable_response, response_in,
    input  response_out, resp_wr, cmd_inhibit, int_status,
    input  new_command, cmd_index, cmd_argument, timeout_enable, ack_response
  );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD host command sequencer: latches a CPU command, launches it on the CMD block,
// waits for completion or timeout, captures the response and keeps sticky status flags.
module sd_cmd_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic         clock,
  input  logic         reset,
  sd_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_LATCH,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  logic [1:0]     rtype_q, rtype_d;
  logic           chk_q, chk_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           tout_q, tout_d;
  logic           newcmd_q, newcmd_d;
  logic           stb_q, stb_d;
  logic [127:0]   resp_q, resp_d;
  logic [2:0]     ist_q, ist_d;
  logic [2:0]     ist_set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      arg_q    <= '0;
      rtype_q  <= '0;
      chk_q    <= 1'b0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
      newcmd_q <= 1'b0;
      stb_q    <= 1'b0;
      resp_q   <= '0;
      ist_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      rtype_q  <= rtype_d;
      chk_q    <= chk_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      newcmd_q <= newcmd_d;
      stb_q    <= stb_d;
      resp_q   <= resp_d;
      ist_q    <= ist_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    rtype_d  = rtype_q;
    chk_d    = chk_q;
    cnt_d    = cnt_q;
    tout_d   = tout_q;
    newcmd_d = 1'b0;
    stb_d    = 1'b0;
    resp_d   = resp_q;
    ist_set  = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_write) begin
          idx_d   = bus.cmd_index_in;
          arg_d   = bus.cmd_argument_in;
          rtype_d = bus.response_type_in;
          chk_d   = bus.index_check_en_in;
          cnt_d   = '0;
          tout_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // new_command is registered, so it is seen in the first WAIT_RESP cycle
        newcmd_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        // Completion has priority over a timeout expiring in the same cycle
        if (bus.command_complete) begin
          if (chk_q && bus.command_index_error) ist_set[2] = 1'b1;
          state_d = (rtype_q != 2'b00) ? S_LATCH : S_DONE;
        end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          ist_set[1] = 1'b1;
          tout_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LATCH: begin
        if (bus.enable_response) begin
          stb_d   = 1'b1;
          resp_d  = (rtype_q == 2'b01) ? bus.response_in : {80'd0, bus.response_in[47:0]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!tout_q) ist_set[0] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A set wins over a clear of the same bit
    ist_d = (ist_q & ~bus.int_clear) | ist_set;
  end

  assign bus.new_command    = newcmd_q;
  assign bus.cmd_index      = idx_q;
  assign bus.cmd_argument   = arg_q;
  assign bus.timeout_enable = (state_q == S_WAIT_RESP);
  assign bus.ack_response   = stb_q;
  assign bus.resp_wr        = stb_q;
  assign bus.response_out   = resp_q;
  assign bus.cmd_inhibit    = (state_q != S_IDLE);
  assign bus.int_status     = ist_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed and randomized bench for sd_cmd_ctrl with a transaction-level reference model.
module tb_sd_cmd_ctrl;
  localparam logic [15:0] T = 16'd20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [127:0] m_resp;
  logic [2:0]   m_ist;

  sd_cmd_ctrl_if bus ();

  sd_cmd_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] expected_capture(input logic [1:0] rt, input logic [127:0] rsp);
    if (rt == 2'b01) return rsp;
    return rsp & ((128'd1 << 48) - 128'd1);
  endfunction

  task automatic clear_status();
    bus.int_clear = 3'b111;
    tick();
    bus.int_clear = 3'b000;
    m_ist = 3'b000;
    chk("status_cleared", bus.int_status, m_ist);
  endtask

  // One whole command. cdel = WAIT_RESP cycle in which command_complete pulses; cdel >= T means never.
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic ce, input int cdel, input logic ierr, input int edel,
                        input logic [127:0] rsp, input logic extra_wr, input logic [2:0] clr_done);
    bit timed_out;
    int waited;
    timed_out = (cdel >= int'(T));

    bus.cmd_write         = 1'b1;
    bus.cmd_index_in      = idx;
    bus.cmd_argument_in   = arg;
    bus.response_type_in  = rt;
    bus.index_check_en_in = ce;
    tick();
    bus.cmd_write = 1'b0;
    chk("inhibit_after_write", bus.cmd_inhibit, 1'b1);
    chk("no_early_new_command", bus.new_command, 1'b0);
    tick();
    chk("new_command_pulse", bus.new_command, 1'b1);
    chk("cmd_index_out", bus.cmd_index, idx);
    chk("cmd_argument_out", bus.cmd_argument, arg);
    chk("timeout_enable_on", bus.timeout_enable, 1'b1);

    waited = 0;
    if (extra_wr) begin
      bus.cmd_write        = 1'b1;
      bus.cmd_index_in     = ~idx;
      bus.cmd_argument_in  = ~arg;
      bus.response_type_in = ~rt;
      tick();
      bus.cmd_write = 1'b0;
      waited = 1;
      chk("ignored_write_index", bus.cmd_index, idx);
      chk("ignored_write_arg", bus.cmd_argument, arg);
      chk("new_command_single", bus.new_command, 1'b0);
    end

    if (timed_out) begin
      while (waited < int'(T)) begin
        tick();
        waited++;
      end
      m_ist[1] = 1'b1;
      chk("timeout_flag", bus.int_status, m_ist);
      chk("timeout_enable_off", bus.timeout_enable, 1'b0);
    end else begin
      while (waited < cdel) begin
        tick();
        waited++;
      end
      bus.command_complete    = 1'b1;
      bus.command_index_error = ierr;
      tick();
      bus.command_complete    = 1'b0;
      bus.command_index_error = 1'b0;
      if (ce && ierr) m_ist[2] = 1'b1;
      chk("timeout_enable_after_complete", bus.timeout_enable, 1'b0);
      if (rt != 2'b00) begin
        for (int i = 0; i < edel; i++) begin
          bus.response_in = {$urandom, $urandom, $urandom, $urandom};
          tick();
        end
        chk("no_ack_before_response", bus.ack_response, 1'b0);
        bus.enable_response = 1'b1;
        bus.response_in     = rsp;
        tick();
        bus.enable_response = 1'b0;
        m_resp = expected_capture(rt, rsp);
        chk("ack_response", bus.ack_response, 1'b1);
        chk("resp_wr", bus.resp_wr, 1'b1);
        chk("response_out", bus.response_out, m_resp);
      end
    end

    // DONE cycle
    chk("inhibit_in_done", bus.cmd_inhibit, 1'b1);
    bus.int_clear = clr_done;
    tick();
    bus.int_clear = 3'b000;
    m_ist = m_ist & ~clr_done;
    if (!timed_out) m_ist[0] = 1'b1;
    chk("int_status_final", bus.int_status, m_ist);
    chk("inhibit_released", bus.cmd_inhibit, 1'b0);
    chk("resp_wr_idle", bus.resp_wr, 1'b0);
    chk("response_held", bus.response_out, m_resp);
  endtask

  initial begin
    logic [127:0] rsp;
    logic [1:0]   rt;
    int           cdel;
    logic         extra;

    checks = 0;
    errors = 0;
    m_resp = '0;
    m_ist  = '0;
    rst_n  = 1'b0;
    bus.cmd_write           = 1'b0;
    bus.cmd_index_in        = '0;
    bus.cmd_argument_in     = '0;
    bus.response_type_in    = '0;
    bus.index_check_en_in   = 1'b0;
    bus.int_clear           = '0;
    bus.command_complete    = 1'b0;
    bus.command_index_error = 1'b0;
    bus.enable_response     = 1'b0;
    bus.response_in         = '0;

    tick();
    tick();
    chk("reset_inhibit", bus.cmd_inhibit, 1'b0);
    chk("reset_status", bus.int_status, 3'b000);
    chk("reset_response", bus.response_out, 128'd0);
    chk("reset_new_command", bus.new_command, 1'b0);
    rst_n = 1'b1;
    tick();

    do_cmd(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 3, 1'b0, 2,
           128'hFFFF_0000_0000_0000_0000_1234_5678_9ABC, 1'b0, 3'b000);
    chk("req41_response", bus.response_out, 128'h0000_0000_0000_0000_0000_1234_5678_9ABC);
    chk("req41_status", bus.int_status, 3'b001);

    clear_status();
    do_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1, 1'b0, 0, '0, 1'b0, 3'b000);
    chk("type00_response_kept", bus.response_out, 128'h0000_0000_0000_0000_0000_1234_5678_9ABC);
    chk("type00_status", bus.int_status, 3'b001);

    clear_status();
    do_cmd(6'd17, 32'hDEAD_BEEF, 2'b10, 1'b0, int'(T), 1'b0, 0, '0, 1'b0, 3'b000);
    chk("timeout_status", bus.int_status, 3'b010);
    clear_status();
    do_cmd(6'd17, 32'hDEAD_BEEF, 2'b00, 1'b0, int'(T) - 1, 1'b0, 0, '0, 1'b0, 3'b000);
    chk("last_cycle_complete_status", bus.int_status, 3'b001);

    clear_status();
    do_cmd(6'd2, 32'h1234_0000, 2'b01, 1'b1, 4, 1'b1, 1,
           128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 3'b000);
    chk("index_error_status", bus.int_status, 3'b101);
    clear_status();
    do_cmd(6'd2, 32'h1234_0000, 2'b11, 1'b0, 4, 1'b1, 0,
           128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, 1'b0, 3'b000);
    chk("index_check_off_status", bus.int_status, 3'b001);

    do_cmd(6'd41, 32'hCAFE_F00D, 2'b10, 1'b0, 5, 1'b0, 0,
           128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 3'b001);
    chk("clear_vs_set_status", bus.int_status, 3'b001);

    for (int n = 0; n < 12; n++) begin
      rsp   = {$urandom, $urandom, $urandom, $urandom};
      rt    = 2'($urandom_range(0, 3));
      cdel  = int'($urandom_range(0, int'(T) + 1));
      extra = (cdel >= 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_cmd(6'($urandom), $urandom, rt, 1'($urandom_range(0, 1)), cdel,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), rsp, extra,
             3'($urandom_range(0, 7)));
    end

    // Reset while sitting in LATCH
    bus.cmd_write        = 1'b1;
    bus.cmd_index_in     = 6'd55;
    bus.cmd_argument_in  = 32'h5555_AAAA;
    bus.response_type_in = 2'b01;
    tick();
    bus.cmd_write = 1'b0;
    tick();
    bus.command_complete = 1'b1;
    tick();
    bus.command_complete = 1'b0;
    chk("latch_inhibit", bus.cmd_inhibit, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_inhibit", bus.cmd_inhibit, 1'b0);
    chk("async_rst_index", bus.cmd_index, 6'd0);
    chk("async_rst_argument", bus.cmd_argument, 32'd0);
    chk("async_rst_response", bus.response_out, 128'd0);
    chk("async_rst_status", bus.int_status, 3'b000);
    chk("async_rst_timeout_en", bus.timeout_enable, 1'b0);
    chk("async_rst_ack", bus.ack_response, 1'b0);
    bus.enable_response = 1'b1;
    bus.response_in     = {$urandom, $urandom, $urandom, $urandom};
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_ack_after_reset", bus.ack_response, 1'b0);
      chk("no_resp_wr_after_reset", bus.resp_wr, 1'b0);
    end
    bus.enable_response = 1'b0;
    chk("idle_after_reset", bus.cmd_inhibit, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
